nibble_merge: RTL and testbench
===============================

# nibble_merge

Reassembles nibble pairs into full client words and returns them to the client over a valid/ready stream. It is the return path of the client-word splitter: pipeline stages produce an upper half `A` and a lower half `B`, and this block joins them as `{A, B}`. It buffers the joined words in a small FIFO so the pipeline is not stalled by short client back-pressure. It can optionally track the running maximum of all words delivered.

## Interface
Parameters:
- `data_width`, 8: client word width; must be even and ≥ 2. Half width H = data_width/2.
- `DEPTH`, 4: FIFO entries; must be a power of two and ≥ 2.

Ports:
- `clk`  in  1: sole clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_val`  in  1: `A`/`B` pair valid.
- `in_rdy`  out  1: block can accept a pair.
- `A`  in  H: upper half of the word.
- `B`  in  H: lower half of the word.
- `client_val`  out  1: `client_data` valid.
- `client_rdy`  in  1: client accepts the word.
- `client_data`  out  data_width: merged word `{A, B}`.
- `max_clr`  in  1: synchronous clear of `max_data`.
- `max_data`  out  data_width: running unsigned maximum of delivered words.

## Operation
- **Input transfer:** occurs when `in_val && in_rdy`. The block writes `{A, B}` to `mem[wr_ptr]` and advances `wr_ptr`, wrapping modulo DEPTH.
- **Output transfer:** occurs when `client_val && client_rdy`. The block advances `rd_ptr`, wrapping modulo DEPTH.
- **Occupancy:** `count` is clog2(DEPTH+1) bits wide. It increments on push-only, decrements on pop-only, and is unchanged on push+pop or on idle.
- **`in_rdy`** = (`count` != DEPTH). It depends only on `count`. There is no full-bypass: when full, no push is accepted, even in a cycle that pops.
- **`client_val`** = (`count` != 0).
- **`client_data`** = `mem[rd_ptr]`, driven combinationally from the storage. It is held stable while `client_val && !client_rdy`.
- **Empty:** no pass-through. A word pushed into an empty FIFO appears on the next cycle.
- **Simultaneous push and pop at partial occupancy:** both take effect, and `count` is unchanged.
- **Ordering:** strict FIFO. The block never drops or duplicates a word.
- **`in_val` while `in_rdy` = 0:** ignored. The source must hold `A`/`B`; the block places no requirement on the source beyond that.
- **Reset (asynchronous, mid-operation included):**
  - `wr_ptr`, `rd_ptr` and `count` go to 0, so `client_val` = 0 and `in_rdy` = 1.
  - `max_data` goes to 0.
  - Stored words are discarded. Storage contents are not reset, and `client_data` is don't-care while `client_val` = 0.

## Timing
- **Latency:** a word accepted at edge N is presented on `client_data` with `client_val` = 1 immediately after edge N. Its earliest client transfer is at edge N+1.
- **Throughput:** one word per cycle sustained when DEPTH ≥ 2 and `client_rdy` is held high.
- **`in_rdy` and `client_val`:** both are pure functions of registered `count`. There are no combinational paths from `in_val` or `client_rdy` to any output.
- **`max_data`:** updates at the edge of the output transfer and is visible the following cycle.

## Configuration
- **Macro `NIBBLE_MERGE_MAX_EN`.**
- **Defined:**
  - On each output transfer, if `client_data` > `max_data` (unsigned compare), then `max_data` <= `client_data`.
  - `max_clr` = 1 sets `max_data` <= 0.
  - When `max_clr` and an output transfer occur in the same cycle, `max_data` <= the transferred word.
- **Undefined:** `max_data` is tied to 0, `max_clr` is ignored, and no compare logic is built. FIFO behaviour is identical in both builds.

## Structure
- **Package `p_pipe_pkg`** holds:
  - the default `data_width` and the half-width constant;
  - the default FIFO depth;
  - a `merge_word_t` typedef for the data_width-bit word.
- **Sub-module `nibble_fifo`** contains the storage, pointers and count. It is instantiated once.
- **Top level** contains only the `{A, B}` concatenation and the optional max tracker.

## Test plan
- **Single word:** after reset, drive `A`=0xA, `B`=0x5, `in_val`=1 for one cycle with `client_rdy`=1. Required: `client_val`=1 with `client_data`=0xA5 the next cycle, then `client_val`=0.
- **Fill and back-pressure:** with `client_rdy`=0, push 0x11, 0x22, 0x33, 0x44. Required: `in_rdy`=0 after the 4th push, and a 5th `in_val` is ignored. Then raise `client_rdy`. Required: words drain as 0x11, 0x22, 0x33, 0x44 on consecutive cycles and `in_rdy` returns to 1.
- **Full with simultaneous pop:** with the FIFO full and `client_rdy`=1 and `in_val`=1 in the same cycle, push 0x55. Required: only the pop occurs, `count` goes to 3, and 0x55 is accepted on the next cycle.
- **Streaming and wrap:** push 20 words 0x00..0x13 back-to-back with `client_rdy`=1. Required: identical order out at one word per cycle, with `count` never exceeding 1.
- **Reset mid-operation:** with 3 words stored, assert `rst_n`=0 asynchronously between edges. Required: `client_val`=0 and `in_rdy`=1 immediately, and after release the next push of 0x7E is the first word out.
- **Max tracker (`NIBBLE_MERGE_MAX_EN`):** deliver 0x30, 0xF1, 0x42. Required: `max_data`=0xF1. Then deliver 0x10 with `max_clr`=1 in the same cycle. Required: `max_data`=0x10. Without the macro, `max_data` stays 0 throughout.

Source files
------------

// File: rtl/nibble_merge_pkg.sv
// Shared constants and word type for the nibble-merge return path.
package p_pipe_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int HALF_WIDTH_DEF = DATA_WIDTH_DEF / 2;
    localparam int DEPTH_DEF      = 4;

    typedef logic [DATA_WIDTH_DEF-1:0] merge_word_t;
endpackage

// File: rtl/nibble_merge_if.sv
// Pair-in / word-out stream bundle; master is the pipeline+client side, slave is the merger.
interface nibble_merge_if
    import p_pipe_pkg::*;
#(
    parameter int data_width = DATA_WIDTH_DEF
) ();
    logic                    in_val;
    logic                    in_rdy;
    logic [data_width/2-1:0] A;
    logic [data_width/2-1:0] B;
    logic                    client_val;
    logic                    client_rdy;
    logic [data_width-1:0]   client_data;

    modport master (
        output in_val, A, B, client_rdy,
        input  in_rdy, client_val, client_data
    );

    modport slave (
        input  in_val, A, B, client_rdy,
        output in_rdy, client_val, client_data
    );
endinterface

// File: rtl/nibble_fifo.sv
// Small FIFO with combinational read of the head entry; ready/valid derive only from count.
module nibble_fifo #(
    parameter int data_width = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push_val,
    output logic                  push_rdy,
    input  logic [data_width-1:0] push_data,
    output logic                  pop_val,
    input  logic                  pop_rdy,
    output logic [data_width-1:0] pop_data
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [data_width-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg;
    logic [PTR_W-1:0]      rd_ptr_reg;
    logic [CNT_W-1:0]      count_reg;
    logic [CNT_W-1:0]      count_next;
    logic                  push;
    logic                  pop;

    // No full bypass: a pop in the same cycle does not make room for a push.
    assign push_rdy = (count_reg != CNT_W'(DEPTH));
    assign pop_val  = (count_reg != '0);
    assign push     = push_val && push_rdy;
    assign pop      = pop_val && pop_rdy;
    assign pop_data = mem[rd_ptr_reg];

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_next;
        end
    end
endmodule

// File: rtl/nibble_merge.sv
// Joins {A, B} halves into client words through nibble_fifo.
// Optional running-maximum tracker enabled by NIBBLE_MERGE_MAX_EN.
module nibble_merge
    import p_pipe_pkg::*;
#(
    parameter int data_width = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nibble_merge_if.slave         bus,
    input  logic                  max_clr,
    output logic [data_width-1:0] max_data
);
    logic [data_width-1:0] merged_word;

    assign merged_word = {bus.A, bus.B};

    nibble_fifo #(
        .data_width (data_width),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_val  (bus.in_val),
        .push_rdy  (bus.in_rdy),
        .push_data (merged_word),
        .pop_val   (bus.client_val),
        .pop_rdy   (bus.client_rdy),
        .pop_data  (bus.client_data)
    );

`ifdef NIBBLE_MERGE_MAX_EN
    logic [data_width-1:0] max_reg;
    logic                  out_fire;

    assign out_fire = bus.client_val && bus.client_rdy;
    assign max_data = max_reg;

    // A delivered word wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_reg <= '0;
        end else if (out_fire && (max_clr || (bus.client_data > max_reg))) begin
            max_reg <= bus.client_data;
        end else if (max_clr) begin
            max_reg <= '0;
        end
    end
`else
    logic unused_max_clr;

    assign unused_max_clr = max_clr;
    assign max_data       = '0;
`endif
endmodule

// File: tb/tb_nibble_merge.sv
// Directed scoreboard bench for nibble_merge; works with or without NIBBLE_MERGE_MAX_EN.
module tb_nibble_merge;
    import p_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        max_clr;
    merge_word_t max_data;

    int          checks = 0;
    int          errors = 0;
    merge_word_t sb[$];
    merge_word_t exp_max = '0;

    nibble_merge_if #(.data_width(8)) bus ();

    nibble_merge #(
        .data_width (8),
        .DEPTH      (4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .max_clr  (max_clr),
        .max_data (max_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Evaluate transfers with the inputs currently driven, advance one cycle, resample at negedge.
    task automatic tick();
        logic        in_fire;
        logic        out_fire;
        merge_word_t w;
        in_fire  = bus.in_val && bus.in_rdy;
        out_fire = bus.client_val && bus.client_rdy;
        if (out_fire) begin
            $display("pop  0x%02h", bus.client_data);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL spurious_word: observed 0x%02h expected no word", bus.client_data);
            end else begin
                w = sb.pop_front();
                chk("client_data", {24'd0, bus.client_data}, {24'd0, w});
            end
        end
`ifdef NIBBLE_MERGE_MAX_EN
        if (out_fire && (max_clr || bus.client_data > exp_max)) exp_max = bus.client_data;
        else if (max_clr) exp_max = '0;
`endif
        if (in_fire) begin
            $display("push 0x%02h", {bus.A, bus.B});
            sb.push_back({bus.A, bus.B});
        end
        @(posedge clk);
        @(negedge clk);
        chk("max_data", {24'd0, max_data}, {24'd0, exp_max});
    endtask

    task automatic push_word(input merge_word_t w);
        bus.A      = w[7:4];
        bus.B      = w[3:0];
        bus.in_val = 1'b1;
        chk("in_rdy_before_push", {31'd0, bus.in_rdy}, 32'd1);
        tick();
        bus.in_val = 1'b0;
    endtask

    task automatic drain(input int budget);
        bus.in_val     = 1'b0;
        bus.client_rdy = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) break;
            tick();
        end
        chk("drain_left", sb.size(), 32'd0);
        chk("drain_client_val", {31'd0, bus.client_val}, 32'd0);
        chk("drain_in_rdy", {31'd0, bus.in_rdy}, 32'd1);
    endtask

    initial begin
        rst_n          = 1'b0;
        max_clr        = 1'b0;
        bus.in_val     = 1'b0;
        bus.A          = '0;
        bus.B          = '0;
        bus.client_rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_client_val", {31'd0, bus.client_val}, 32'd0);
        chk("rst_in_rdy", {31'd0, bus.in_rdy}, 32'd1);
        chk("rst_max_data", {24'd0, max_data}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word
        bus.client_rdy = 1'b1;
        push_word(8'hA5);
        chk("single_val", {31'd0, bus.client_val}, 32'd1);
        chk("single_data", {24'd0, bus.client_data}, 32'h0000_00A5);
        tick();
        chk("single_empty", {31'd0, bus.client_val}, 32'd0);

        // Fill and back-pressure
        bus.client_rdy = 1'b0;
        push_word(8'h11);
        push_word(8'h22);
        push_word(8'h33);
        push_word(8'h44);
        chk("full_in_rdy", {31'd0, bus.in_rdy}, 32'd0);
        chk("full_head", {24'd0, bus.client_data}, 32'h0000_0011);
        bus.A = 4'h9; bus.B = 4'h9; bus.in_val = 1'b1;
        tick();
        bus.in_val = 1'b0;
        chk("hold_head", {24'd0, bus.client_data}, 32'h0000_0011);
        chk("still_full", {31'd0, bus.in_rdy}, 32'd0);
        bus.client_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_consecutive", {31'd0, bus.client_val}, 32'd1);
            tick();
        end
        chk("drained_val", {31'd0, bus.client_val}, 32'd0);
        chk("drained_rdy", {31'd0, bus.in_rdy}, 32'd1);

        // Full with simultaneous pop: no bypass
        bus.client_rdy = 1'b0;
        push_word(8'hA1);
        push_word(8'hA2);
        push_word(8'hA3);
        push_word(8'hA4);
        bus.A = 4'h5; bus.B = 4'h5; bus.in_val = 1'b1; bus.client_rdy = 1'b1;
        chk("bypass_in_rdy", {31'd0, bus.in_rdy}, 32'd0);
        tick();
        chk("after_pop_in_rdy", {31'd0, bus.in_rdy}, 32'd1);
        tick();
        bus.in_val = 1'b0;
        drain(10);

        // Streaming and wrap
        bus.client_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push_word(merge_word_t'(i));
            chk("stream_val", {31'd0, bus.client_val}, 32'd1);
            chk("stream_rdy", {31'd0, bus.in_rdy}, 32'd1);
        end
        drain(10);

        // Asynchronous reset mid-operation
        bus.client_rdy = 1'b0;
        push_word(8'hC1);
        push_word(8'hC2);
        push_word(8'hC3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_client_val", {31'd0, bus.client_val}, 32'd0);
        chk("arst_in_rdy", {31'd0, bus.in_rdy}, 32'd1);
        chk("arst_max_data", {24'd0, max_data}, 32'd0);
        sb.delete();
        exp_max = '0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        bus.client_rdy = 1'b1;
        push_word(8'h7E);
        chk("post_rst_head", {24'd0, bus.client_data}, 32'h0000_007E);
        drain(10);

        // Max tracker
        push_word(8'h30);
        push_word(8'hF1);
        push_word(8'h42);
        drain(10);
`ifdef NIBBLE_MERGE_MAX_EN
        chk("max_f1", {24'd0, max_data}, 32'h0000_00F1);
`else
        chk("max_off", {24'd0, max_data}, 32'd0);
`endif
        bus.client_rdy = 1'b0;
        push_word(8'h10);
        max_clr        = 1'b1;
        bus.client_rdy = 1'b1;
        tick();
        max_clr = 1'b0;
`ifdef NIBBLE_MERGE_MAX_EN
        chk("max_clr_with_pop", {24'd0, max_data}, 32'h0000_0010);
`else
        chk("max_off_clr", {24'd0, max_data}, 32'd0);
`endif
        drain(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
